s2p_comma_align: RTL and testbench
==================================

Name: s2p_comma_align

Overview:
Receive-side serial-to-parallel stage. Takes the 1-bit serial lane on clk_32f and finds byte alignment by hunting for the COMMA symbol (0xBC). After SYNC_COUNT consecutive aligned commas it asserts sinc, then delivers bytes with a valid flag.
Sits directly upstream of the 8→32 packer. It supplies that stage's data_input, valid_input and sinc. Rate conversion from the byte_stb domain to clk_4f is done at integration level.

Parameters:
COMMA, 8'hBC, alignment/idle symbol
SYNC_COUNT, 4, consecutive aligned commas required to declare sync (range 1..15)

Ports:
clk_32f  input  1  bit clock, single clock domain, all logic on posedge
reset  input  1  synchronous, active-high; clears all state on the clock edge where it is sampled high
serial_in  input  1  serial data, MSB of each byte first
data_out  output  8  last byte received while in ACTIVE
valid_out  output  1  high when data_out holds a non-COMMA byte
byte_stb  output  1  one-cycle pulse when data_out/valid_out update
sinc  output  1  high while synchronized (ACTIVE)

Behaviour:
- Reset values: data_out=8'h00, valid_out=0, byte_stb=0, sinc=0. Internal state: state=HUNT, sr=0, bit_cnt=0, bc_cnt=0.
- Reset dominates any other event on the same edge, including mid-byte and mid-ACTIVE.
- Every edge (reset low): nxt = {sr[6:0], serial_in}; sr <= nxt[6:0].
- Boundary edge: bit_cnt==7 in ALIGN/ACTIVE. bit_cnt wraps to 0 on that edge, otherwise increments.
- FSM states: HUNT, ALIGN, ACTIVE.
- HUNT, checked every edge:
  - if nxt==COMMA: bit_cnt<=0, bc_cnt<=1; go to ACTIVE if SYNC_COUNT==1, else ALIGN.
  - bit_cnt is ignored in HUNT.
- ALIGN, at boundary edges only:
  - nxt==COMMA: bc_cnt++; if the new count equals SYNC_COUNT, go to ACTIVE and set sinc<=1.
  - nxt!=COMMA: go to HUNT, bc_cnt<=0.
  - No outputs change in ALIGN.
- ACTIVE, at boundary edge:
  - data_out<=nxt, valid_out<=(nxt!=COMMA), byte_stb<=1.
  - On all other edges byte_stb<=0; data_out and valid_out hold.
- Latency: outputs update on the same edge that samples a byte's 8th bit. byte_stb fires once every 8 cycles in ACTIVE.
- sinc rises on the edge that samples the last bit of the SYNC_COUNT-th comma. It stays 1 until reset, or until loss of sync (optional feature).
- Commas inside the data stream in ACTIVE are legal idles: valid_out=0, data_out=8'hBC, sinc unchanged.
- bc_cnt saturates; it is unused in ACTIVE.
- Leading garbage bits of any length before the first comma are discarded.

Optional Feature:
Macro S2P_RESYNC_EN.
- Defined:
  - In ACTIVE, a misalignment counter (2 bits) tracks off-boundary commas.
  - On each non-boundary edge where nxt==COMMA, the counter sets a per-byte flag.
  - At each boundary: if the flag is set, the counter increments, otherwise it clears. The flag then clears.
  - When the counter reaches 2 (two consecutive byte windows containing an off-boundary comma): state<=HUNT, sinc<=0, valid_out<=0, bc_cnt<=0. data_out holds.
- Undefined: no misalignment logic; ACTIVE exits only via reset.

Test Plan:
- Reset 3 cycles, then serial BC,BC,BC,BC,EE,AA MSB first -> sinc=1 on the edge of the 32nd bit. byte_stb pulses at bits 40 and 48 with data_out=EE then AA, valid_out=1 both times.
- 3 garbage bits 3'b101, then 4×BC, then DD -> lock still achieved. sinc rises on bit 35, data_out=DD valid_out=1 at bit 43.
- BC,BC,00,BC,BC,BC,BC -> sinc stays 0 through the 00 byte (return to HUNT). sinc rises only after the last four BCs.
- After sync: 11, BC, 22 -> data_out=11/valid=1, then BC/valid=0 with sinc=1, then 22/valid=1.
- Assert reset for 1 cycle mid-byte while ACTIVE -> next edge shows all outputs 0, state HUNT. A full 4×BC sequence is needed to re-sync.
- With S2P_RESYNC_EN: after sync, shift the stream by 3 bits and send BC repeatedly -> sinc drops after the second affected byte window, then re-locks after 4 aligned commas at the new offset. Without the macro, sinc stays 1.

Source files
------------

// File: rtl/s2p_comma_align_if.sv
// Serial lane and byte-side outputs of the comma aligner.
// master is the aligner side, slave is the stimulus/consumer side.
interface s2p_comma_align_if;
    logic       serial_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_stb;
    logic       sinc;

    modport master (
        input  serial_in,
        output data_out,
        output valid_out,
        output byte_stb,
        output sinc
    );

    modport slave (
        output serial_in,
        input  data_out,
        input  valid_out,
        input  byte_stb,
        input  sinc
    );
endinterface

// File: rtl/s2p_comma_align.sv
// Serial-to-parallel receiver that hunts for COMMA and locks byte alignment.
// Define S2P_RESYNC_EN to drop sync after two byte windows with off-boundary commas.
module s2p_comma_align #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned SYNC_COUNT = 4
) (
    input  logic                  clk_32f,
    input  logic                  reset,
    s2p_comma_align_if.master     bus
);

    localparam logic [3:0] SyncCount = 4'(SYNC_COUNT);

    typedef enum logic [1:0] {StHunt, StAlign, StActive} state_e;

    state_e     state_q, state_d;
    logic [6:0] sr_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] bc_cnt_q, bc_cnt_d;
    logic [3:0] bc_inc;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       stb_q, stb_d;
    logic       sinc_q, sinc_d;
    logic [7:0] nxt;
    logic       is_comma;
    logic       boundary;

`ifdef S2P_RESYNC_EN
    logic [1:0] mis_q, mis_d;
    logic [1:0] mis_inc;
    logic       flag_q, flag_d;
`endif

    assign nxt      = {sr_q, bus.serial_in};
    assign is_comma = (nxt == COMMA);
    assign boundary = (state_q != StHunt) && (bit_cnt_q == 3'd7);
    assign bc_inc   = (bc_cnt_q == 4'hF) ? bc_cnt_q : bc_cnt_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        bc_cnt_d  = bc_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        stb_d     = 1'b0;
        sinc_d    = sinc_q;
`ifdef S2P_RESYNC_EN
        mis_d     = mis_q;
        flag_d    = flag_q;
        mis_inc   = flag_q ? mis_q + 2'd1 : 2'd0;
`endif
        unique case (state_q)
            StHunt: begin
                if (is_comma) begin
                    bit_cnt_d = 3'd0;
                    bc_cnt_d  = 4'd1;
                    if (SYNC_COUNT == 1) begin
                        state_d = StActive;
                        sinc_d  = 1'b1;
                    end else begin
                        state_d = StAlign;
                    end
                end
            end
            StAlign: begin
                if (boundary) begin
                    if (is_comma) begin
                        bc_cnt_d = bc_inc;
                        if (bc_inc == SyncCount) begin
                            state_d = StActive;
                            sinc_d  = 1'b1;
                        end
                    end else begin
                        state_d  = StHunt;
                        bc_cnt_d = 4'd0;
                    end
                end
            end
            StActive: begin
`ifdef S2P_RESYNC_EN
                if (!boundary && is_comma) begin
                    flag_d = 1'b1;
                end
                if (boundary) begin
                    flag_d = 1'b0;
                    mis_d  = mis_inc;
                    // Second consecutive window with a stray comma: alignment is lost.
                    if (mis_inc == 2'd2) begin
                        state_d  = StHunt;
                        sinc_d   = 1'b0;
                        valid_d  = 1'b0;
                        bc_cnt_d = 4'd0;
                        mis_d    = 2'd0;
                    end else begin
                        data_d  = nxt;
                        valid_d = !is_comma;
                        stb_d   = 1'b1;
                    end
                end
`else
                if (boundary) begin
                    data_d  = nxt;
                    valid_d = !is_comma;
                    stb_d   = 1'b1;
                end
`endif
            end
            default: state_d = StHunt;
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q   <= StHunt;
            sr_q      <= 7'd0;
            bit_cnt_q <= 3'd0;
            bc_cnt_q  <= 4'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            stb_q     <= 1'b0;
            sinc_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= nxt[6:0];
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            stb_q     <= stb_d;
            sinc_q    <= sinc_d;
        end
    end

`ifdef S2P_RESYNC_EN
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            mis_q  <= 2'd0;
            flag_q <= 1'b0;
        end else begin
            mis_q  <= mis_d;
            flag_q <= flag_d;
        end
    end
`endif

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.byte_stb  = stb_q;
    assign bus.sinc      = sinc_q;

endmodule

// File: tb/tb_s2p_comma_align.sv
// Bench for s2p_comma_align: directed lock scenarios plus randomized streams,
// every edge compared against a bit-position reference model.
module tb_s2p_comma_align;

    localparam logic [7:0] Comma     = 8'hBC;
    localparam int         SyncCount = 4;

    logic clk_32f = 1'b0;
    logic reset;

    s2p_comma_align_if bus ();

    s2p_comma_align #(
        .COMMA      (Comma),
        .SYNC_COUNT (SyncCount)
    ) u_dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_32f = ~clk_32f;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: alignment is tracked as the absolute bit index of the
    // comma that opened the lock; byte edges fall every 8 bits after it.
    logic [7:0] m_win;
    int         m_mode;    // 0 hunting, 1 counting commas, 2 locked
    int         m_pos;
    int         m_anchor;
    int         m_cnt;
    int         m_stray_run;
    bit         m_stray_seen;
    logic [7:0] m_data;
    logic       m_valid, m_stb, m_sinc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic b, input logic r);
        logic [7:0] w;
        bit         edge_b;
        if (r) begin
            m_win = 8'h00; m_mode = 0; m_pos = 0; m_anchor = 0; m_cnt = 0;
            m_stray_run = 0; m_stray_seen = 0;
            m_data = 8'h00; m_valid = 0; m_stb = 0; m_sinc = 0;
            return;
        end
        w      = {m_win[6:0], b};
        edge_b = (m_mode != 0) && (m_pos > m_anchor) && (((m_pos - m_anchor) % 8) == 0);
        m_stb  = 0;
        if (m_mode == 0) begin
            if (w == Comma) begin
                m_anchor = m_pos;
                m_cnt    = 1;
                m_mode   = (SyncCount == 1) ? 2 : 1;
                if (m_mode == 2) m_sinc = 1;
            end
        end else if (m_mode == 1) begin
            if (edge_b) begin
                if (w == Comma) begin
                    if (m_cnt < 15) m_cnt++;
                    if (m_cnt == SyncCount) begin
                        m_mode = 2;
                        m_sinc = 1;
                    end
                end else begin
                    m_mode = 0;
                    m_cnt  = 0;
                end
            end
        end else begin
            bit drop;
            drop = 0;
`ifdef S2P_RESYNC_EN
            if (!edge_b && w == Comma) m_stray_seen = 1;
            if (edge_b) begin
                m_stray_run  = m_stray_seen ? m_stray_run + 1 : 0;
                m_stray_seen = 0;
                if (m_stray_run >= 2) drop = 1;
            end
`endif
            if (drop) begin
                m_mode = 0; m_sinc = 0; m_valid = 0; m_cnt = 0; m_stray_run = 0;
            end else if (edge_b) begin
                m_data  = w;
                m_valid = (w != Comma);
                m_stb   = 1;
            end
        end
        m_win = w;
        m_pos++;
    endtask

    task automatic step(input logic b, input logic r);
        bus.serial_in = b;
        reset         = r;
        @(posedge clk_32f);
        #1;
        model_step(b, r);
        check_eq("outputs", {21'd0, bus.sinc, bus.byte_stb, bus.valid_out, bus.data_out},
                 {21'd0, m_sinc, m_stb, m_valid, m_data});
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(v[i], 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    initial begin
        bus.serial_in = 1'b0;
        reset         = 1'b1;

        // Reset then basic lock and two data bytes
        do_reset(3);
        check_eq("reset_outs", {21'd0, bus.sinc, bus.byte_stb, bus.valid_out, bus.data_out}, 32'd0);
        for (int k = 0; k < 3; k++) send_byte(Comma);
        check_eq("pre_lock_sinc", {31'd0, bus.sinc}, 32'd0);
        send_byte(Comma);
        check_eq("lock_sinc_bit32", {31'd0, bus.sinc}, 32'd1);
        send_byte(8'hEE);
        check_eq("byte_ee", {22'd0, bus.byte_stb, bus.valid_out, bus.data_out}, {22'd0, 2'b11, 8'hEE});
        send_byte(8'hAA);
        check_eq("byte_aa", {22'd0, bus.byte_stb, bus.valid_out, bus.data_out}, {22'd0, 2'b11, 8'hAA});
        step(1'b0, 1'b0);
        check_eq("stb_one_cycle", {31'd0, bus.byte_stb}, 32'd0);

        // Leading garbage bits
        do_reset(1);
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(Comma);
        check_eq("garbage_lock", {31'd0, bus.sinc}, 32'd1);
        send_byte(8'hDD);
        check_eq("garbage_dd", {23'd0, bus.valid_out, bus.data_out}, {23'd0, 1'b1, 8'hDD});

        // Broken comma run returns to hunting
        do_reset(1);
        send_byte(Comma); send_byte(Comma); send_byte(8'h00);
        check_eq("broken_run", {31'd0, bus.sinc}, 32'd0);
        for (int k = 0; k < 3; k++) send_byte(Comma);
        check_eq("broken_3", {31'd0, bus.sinc}, 32'd0);
        send_byte(Comma);
        check_eq("broken_relock", {31'd0, bus.sinc}, 32'd1);

        // Idle comma inside data
        send_byte(8'h11);
        check_eq("data_11", {23'd0, bus.valid_out, bus.data_out}, {23'd0, 1'b1, 8'h11});
        send_byte(Comma);
        check_eq("idle_bc", {22'd0, bus.sinc, bus.valid_out, bus.data_out}, {22'd0, 2'b10, Comma});
        send_byte(8'h22);
        check_eq("data_22", {23'd0, bus.valid_out, bus.data_out}, {23'd0, 1'b1, 8'h22});

        // Reset mid-byte while locked
        step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check_eq("midbyte_reset", {21'd0, bus.sinc, bus.byte_stb, bus.valid_out, bus.data_out}, 32'd0);
        for (int k = 0; k < 3; k++) send_byte(Comma);
        check_eq("resync_3", {31'd0, bus.sinc}, 32'd0);
        send_byte(Comma);
        check_eq("resync_4", {31'd0, bus.sinc}, 32'd1);

        // Three-bit slip followed by a comma stream
        step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int k = 0; k < 12; k++) send_byte(Comma);
        check_eq("slip_final_sinc", {31'd0, bus.sinc}, 32'd1);

        // Randomized sessions
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 3) == 0) do_reset($urandom_range(1, 2));
            for (int g = $urandom_range(0, 12); g > 0; g--) step(1'($urandom), 1'b0);
            for (int k = $urandom_range(2, 5); k > 0; k--) send_byte(Comma);
            for (int k = $urandom_range(4, 20); k > 0; k--) begin
                if ($urandom_range(0, 9) == 0)
                    for (int g = $urandom_range(1, 7); g > 0; g--) step(1'($urandom), 1'b0);
                if ($urandom_range(0, 4) == 0) send_byte(Comma);
                else send_byte(8'($urandom));
                if ($urandom_range(0, 29) == 0) step(1'($urandom), 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
